// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU types: machine word, opcode field encoding, the entry
//   stored by the fetch queue, and small decode helpers used by fetch.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int OPCODE_W = 6;

  // Primary opcode field, instruction bits [31:26].
  typedef enum logic [OPCODE_W-1:0] {
    RTYPE  = 6'b000000,
    REGIMM = 6'b000001,
    J      = 6'b000010,
    JAL    = 6'b000011,
    BEQ    = 6'b000100,
    BNE    = 6'b000101,
    ADDIU  = 6'b001001,
    SLTI   = 6'b001010,
    SLTIU  = 6'b001011,
    ANDI   = 6'b001100,
    ORI    = 6'b001101,
    XORI   = 6'b001110,
    LUI    = 6'b001111,
    LW     = 6'b100011,
    SW     = 6'b101011,
    HALT   = 6'b111111
  } opcode_t;

  // Byte distance between consecutive instructions.
  localparam word_t WORD_BYTES = 32'd4;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  // True when the word carries the HALT opcode.
  function automatic logic is_halt(input word_t w);
    return (w[31:26] == HALT);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
//   DEPTH-entry circular buffer of fetch entries. Pointers are
//   $clog2(DEPTH) bits and wrap naturally (DEPTH is a power of two);
//   the occupancy counter is one bit wider so "full" is representable.
//   Storage is not reset; only pointers and count are.
// Ports:
//   CLK, nRST     clock, asynchronous active-low reset
//   i_push        write i_push_data at the tail (ignored when full)
//   i_push_data   entry to write
//   i_pop         drop the head entry (ignored when empty)
//   i_flush       discard all entries; beats push and pop
//   o_head        entry at the head (undefined content when empty)
//   o_count       number of valid entries, 0..DEPTH
//   o_full        o_count == DEPTH
//   o_empty       o_count == 0
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Effective push/pop after flush priority and full/empty guards.
  always_comb begin
    w_do_push = i_push && !o_full && !i_flush;
    w_do_pop  = i_pop && !o_empty && !i_flush;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; deliberately without reset.
  always_ff @(posedge CLK) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Head entry and status flags.
  always_comb begin
    o_head  = r_mem[r_rd_ptr];
    o_count = r_count;
    o_full  = (r_count == DEPTH_CNT);
    o_empty = (r_count == {CNT_W{1'b0}});
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Prefetching instruction fetch. Owns the fetch PC, keeps one
//   instruction request outstanding on the cache's instruction side
//   while there is queue room, and hands queued words (with their PCs)
//   to decode through a valid/ready handshake. A redirect flushes the
//   queue and restarts fetch; a queued HALT word stops fetching until
//   the next redirect.
// Ports:
//   CLK, nRST     clock, asynchronous active-low reset
//   ihit          imemload is valid for imemaddr this cycle
//   imemload      returned instruction word
//   imemREN       instruction read request
//   imemaddr      request address (the fetch PC)
//   redirect      flush and restart at redirect_pc
//   redirect_pc   restart address; bits [1:0] are forced to zero
//   out_ready     decode accepts the head entry
//   out_valid     queue holds at least one entry
//   out_instr     head instruction word (0 when empty)
//   out_pc        PC of the head instruction (0 when empty)
//   out_npc       out_pc + 4
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter int    DEPTH   = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t imemload,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  out_ready,
  output logic  out_valid,
  output word_t out_instr,
  output word_t out_pc,
  output word_t out_npc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  word_t r_fetch_pc;
  logic  r_stopped;

  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;
  logic [CNT_W-1:0] w_q_count;
  logic             w_q_full;
  logic             w_q_empty;
  logic             w_push;
  logic             w_pop;

  // Request, push and pop qualification. A word is only taken when a
  // request was actually presented, so a hit during redirect is dropped.
  always_comb begin
    imemREN          = !r_stopped && !redirect && !w_q_full;
    imemaddr         = r_fetch_pc;
    w_push           = imemREN && ihit;
    w_pop            = !w_q_empty && out_ready;
    w_push_data.pc    = r_fetch_pc;
    w_push_data.instr = imemload;
  end

  // Fetch PC and HALT-stop flag; redirect overrides any push.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetch_pc <= PC_INIT;
      r_stopped  <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_stopped  <= 1'b0;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + WORD_BYTES;
      r_stopped  <= r_stopped | is_halt(imemload);
    end else begin
      r_fetch_pc <= r_fetch_pc;
      r_stopped  <= r_stopped;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK         (CLK),
    .nRST        (nRST),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect),
    .o_head      (w_head),
    .o_count     (w_q_count),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty)
  );

  // Decode-side view; storage is unreset, so data is gated to zero
  // while the queue is empty.
  always_comb begin
    out_valid = (w_q_count != {CNT_W{1'b0}});
    if (out_valid) begin
      out_instr = w_head.instr;
      out_pc    = w_head.pc;
    end else begin
      out_instr = 32'h0000_0000;
      out_pc    = 32'h0000_0000;
    end
    out_npc = out_pc + WORD_BYTES;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_types_pkg::*;

  localparam word_t PC0   = 32'h0000_0100;
  localparam int    DEPTH = 4;
  localparam word_t W_HALT  = 32'hFC00_0000;
  localparam word_t W_ADDIU = 32'h2401_0005;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  ihit;
  word_t imemload;
  logic  imemREN;
  word_t imemaddr;
  logic  redirect;
  word_t redirect_pc;
  logic  out_ready;
  logic  out_valid;
  word_t out_instr;
  word_t out_pc;
  word_t out_npc;

  fetch_unit #(.PC_INIT(PC0), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_ready(out_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_npc(out_npc)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_q[$];     // {pc, instr}, head at index 0
  word_t       m_fpc;
  bit          m_stopped;
  bit          m_have_last;
  word_t       m_last_pc;
  bit          chk_en = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_fpc       = PC0;
    m_stopped   = 1'b0;
    m_have_last = 1'b0;
  endtask

  // Compare DUT against the model mid-cycle, then advance the model with
  // the inputs that will be sampled at the coming rising edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      logic  e_ren;
      word_t e_pc, e_in;
      e_ren = !m_stopped && !redirect && (m_q.size() < DEPTH);
      chk("imemREN", {31'd0, imemREN}, {31'd0, e_ren});
      chk("imemaddr", imemaddr, m_fpc);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
      if (m_q.size() > 0) begin
        e_pc = m_q[0][63:32];
        e_in = m_q[0][31:0];
      end else begin
        e_pc = 32'd0;
        e_in = 32'd0;
      end
      chk("out_instr", out_instr, e_in);
      chk("out_pc", out_pc, e_pc);
      chk("out_npc", out_npc, e_pc + 32'd4);
      // popped PC stream must step by exactly 4 between redirects
      if (!redirect && m_q.size() > 0 && out_ready) begin
        if (m_have_last) chk("pop_stream", out_pc, m_last_pc + 32'd4);
        m_last_pc   = e_pc;
        m_have_last = 1'b1;
      end
      // advance
      if (redirect) begin
        m_q.delete();
        m_fpc       = {redirect_pc[31:2], 2'b00};
        m_stopped   = 1'b0;
        m_have_last = 1'b0;
      end else begin
        if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
        if (e_ren && ihit) begin
          m_q.push_back({m_fpc, imemload});
          if (imemload[31:26] == 6'h3F) m_stopped = 1'b1;
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic word_t nh();
    word_t w = $urandom;
    if (w[31:26] == 6'h3F) w[31:26] = 6'h09;
    return w;
  endfunction

  task automatic cyc(input logic ih, input word_t ld, input logic rdy,
                     input logic rd, input word_t rpc);
    @(posedge CLK); #1;
    ihit = ih; imemload = ld; out_ready = rdy; redirect = rd; redirect_pc = rpc;
    @(negedge CLK); #1;
  endtask

  task automatic release_reset();
    @(posedge CLK); #1;
    model_reset();
    nRST   = 1'b1;
    chk_en = 1'b1;
    @(negedge CLK); #1;
  endtask

  word_t saved;

  initial begin
    nRST = 1'b0; ihit = 1'b1; imemload = nh(); out_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'd0;
    #12;
    // reset values
    chk("rst_imemREN", {31'd0, imemREN}, 32'd1);
    chk("rst_imemaddr", imemaddr, PC0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_npc", out_npc, 32'd4);

    // 1: sequential fetch from PC_INIT
    release_reset();
    chk("t1_addr0", imemaddr, 32'h100);
    cyc(1'b1, nh(), 1'b1, 1'b0, 32'd0);
    chk("t1_addr1", imemaddr, 32'h104);
    chk("t1_pc1", out_pc, 32'h100);
    cyc(1'b1, nh(), 1'b1, 1'b0, 32'd0);
    chk("t1_addr2", imemaddr, 32'h108);
    chk("t1_pc2", out_pc, 32'h104);

    // 2: stall fill and single-pop refetch
    cyc(1'b1, nh(), 1'b0, 1'b1, 32'h100);
    for (int i = 0; i < 4; i++) cyc(1'b1, nh(), 1'b0, 1'b0, 32'd0);
    cyc(1'b1, nh(), 1'b0, 1'b0, 32'd0);
    chk("t2_full_ren", {31'd0, imemREN}, 32'd0);
    chk("t2_full_addr", imemaddr, 32'h110);
    cyc(1'b1, nh(), 1'b0, 1'b0, 32'd0);
    chk("t2_hold_ren", {31'd0, imemREN}, 32'd0);
    cyc(1'b1, nh(), 1'b1, 1'b0, 32'd0);
    chk("t2_pop_ren", {31'd0, imemREN}, 32'd0);
    cyc(1'b1, nh(), 1'b0, 1'b0, 32'd0);
    chk("t2_refetch_ren", {31'd0, imemREN}, 32'd1);
    chk("t2_refetch_addr", imemaddr, 32'h110);
    chk("t2_head_pc", out_pc, 32'h104);
    cyc(1'b1, nh(), 1'b0, 1'b0, 32'd0);
    chk("t2_refull_ren", {31'd0, imemREN}, 32'd0);
    chk("t2_refull_addr", imemaddr, 32'h114);

    // 3: redirect with 3 entries queued, same-cycle hit dropped
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, nh(), 1'b0, 1'b0, 32'd0);
    cyc(1'b1, nh(), 1'b0, 1'b1, 32'h2002);
    chk("t3_valid_before", {31'd0, out_valid}, 32'd1);
    cyc(1'b0, nh(), 1'b0, 1'b0, 32'd0);
    chk("t3_valid_after", {31'd0, out_valid}, 32'd0);
    chk("t3_addr", imemaddr, 32'h2000);
    saved = nh();
    cyc(1'b1, saved, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, nh(), 1'b0, 1'b0, 32'd0);
    chk("t3_new_pc", out_pc, 32'h2000);
    chk("t3_new_instr", out_instr, saved);

    // 4: ADDIU then HALT stops fetch; redirect resumes
    cyc(1'b1, nh(), 1'b1, 1'b1, 32'h300);
    cyc(1'b1, W_ADDIU, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, W_HALT, 1'b1, 1'b0, 32'd0);
    chk("t4_addiu", out_instr, W_ADDIU);
    chk("t4_addiu_pc", out_pc, 32'h300);
    cyc(1'b1, nh(), 1'b1, 1'b0, 32'd0);
    chk("t4_halt", out_instr, W_HALT);
    chk("t4_halt_ren", {31'd0, imemREN}, 32'd0);
    chk("t4_halt_addr", imemaddr, 32'h308);
    cyc(1'b1, nh(), 1'b1, 1'b0, 32'd0);
    chk("t4_stopped_ren", {31'd0, imemREN}, 32'd0);
    chk("t4_stopped_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, nh(), 1'b1, 1'b1, 32'h40);
    cyc(1'b1, nh(), 1'b1, 1'b0, 32'd0);
    chk("t4_resume_ren", {31'd0, imemREN}, 32'd1);
    chk("t4_resume_addr", imemaddr, 32'h40);

    // 5: random gaps, backpressure, occasional HALT and redirect
    for (int i = 0; i < 600; i++) begin
      word_t w;
      logic  rd;
      w = ($urandom_range(15) == 0) ? (W_HALT | ($urandom & 32'h03FF_FFFF)) : nh();
      rd = ($urandom_range(31) == 0);
      cyc($urandom_range(2) != 0, w, $urandom_range(1) == 1, rd, $urandom);
    end

    // 6: asynchronous reset with two entries queued
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h500);
    cyc(1'b1, nh(), 1'b0, 1'b0, 32'd0);
    cyc(1'b1, nh(), 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("t6_valid_pre", {31'd0, out_valid}, 32'd1);
    chk("t6_addr_pre", imemaddr, 32'h508);
    chk_en = 1'b0;
    nRST = 1'b0;
    #1;
    chk("t6_valid_async", {31'd0, out_valid}, 32'd0);
    chk("t6_addr_async", imemaddr, PC0);
    chk("t6_ren_async", {31'd0, imemREN}, 32'd1);
    chk("t6_npc_async", out_npc, 32'd4);
    ihit = 1'b1; out_ready = 1'b1; imemload = nh();
    #10;
    release_reset();
    for (int i = 0; i < 20; i++) cyc($urandom_range(1) == 1, nh(), $urandom_range(1) == 1, 1'b0, 32'd0);

    @(posedge CLK); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
